snn_layer_scheduler: RTL and testbench
======================================

# snn_layer_scheduler

Sequencer for a single time-multiplexed dense-layer engine that runs a complete multi-layer SNN inference per input sample. It accepts a sample from upstream, launches the engine once per layer via the engine's valid/ready handshakes, and steers the engine's input mux and ping-pong activation buffers. After the last layer it presents the result downstream. It sits between the sample source, the shared dense engine and its weight/activation storage, and the classifier/output stage.

## Interface
- NUM_LAYERS, 3: layers run per sample, 1..16.
- LAYER_W, 4: width of layer index (≥ max(1, clog2(NUM_LAYERS))).
- TIMEOUT_CYCLES, 0: engine watchdog limit in cycles; 0 = disabled.
- CNT_W, 16: width of sample and latency counters.

- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  scheduler can accept a sample.
- in_capture  out  1  pulse: latch upstream sample into sample register (= s_valid & s_ready).
- eng_valid  out  1  to engine i_valid.
- eng_ready  in  1  from engine i_ready.
- eng_o_valid  in  1  from engine o_valid.
- eng_o_ready  out  1  to engine o_ready.
- layer_sel  out  LAYER_W  layer index; selects weight/bias bank and sizes.
- src_sel  out  2  engine input mux: 0 = sample register, 1 = buffer A, 2 = buffer B.
- buf_wr_en  out  1  write engine output into activation buffer.
- buf_wr_sel  out  1  0 = buffer A, 1 = buffer B.
- out_sel  out  1  buffer holding the final result, constant (NUM_LAYERS-1)%2.
- m_valid  out  1  final result valid downstream.
- m_ready  in  1  downstream accept.
- abort  in  1  synchronous abort.
- clr_err  in  1  clear timeout error.
- busy  out  1  state ≠ IDLE.
- err_timeout  out  1  sticky watchdog error.
- sample_cnt  out  CNT_W  completed samples, wraps.
- last_latency  out  CNT_W  cycles from sample accept to m_valid for last sample, saturating.

## Operation
- States: IDLE, LAUNCH, WAIT, CAPTURE, OUTPUT, ERROR.
- IDLE: s_ready=1. On s_valid: in_capture=1, layer_sel←0, latency counter←0, go LAUNCH.
- LAUNCH: eng_valid=1. Hold src_sel stable. When eng_ready=1, go WAIT.
- WAIT: eng_valid=0 and eng_o_ready=0. Watchdog increments each cycle. If eng_o_valid=1, go CAPTURE. If TIMEOUT_CYCLES≠0 and watchdog reaches TIMEOUT_CYCLES first, set err_timeout and go ERROR.
- CAPTURE: single cycle with eng_o_ready=1, buf_wr_en=1, buf_wr_sel=layer_sel[0].
  - If layer_sel = NUM_LAYERS-1: go OUTPUT.
  - Otherwise: layer_sel←layer_sel+1, go LAUNCH.
- src_sel is 0 for layer 0. For layer k>0 it is 1+((k-1)%2), i.e. the buffer written by layer k-1.
- OUTPUT: m_valid=1, held until m_ready. On m_ready: sample_cnt++, last_latency←latency counter, go IDLE.
- ERROR: all handshake outputs 0. Leave only on clr_err: err_timeout←0, go IDLE.
- abort has priority over every transition in all states. Next state is IDLE. layer_sel, watchdog and latency counter clear. sample_cnt and last_latency are unchanged. err_timeout is unchanged, but abort does exit ERROR.
- The engine itself is not reset by abort. The next LAUNCH stalls until eng_ready returns.
- Watchdog clears on entry to WAIT. It counts only in WAIT.
- Latency counter runs in every state except IDLE and ERROR, and saturates at all-ones.

## Timing
- Reset values: state IDLE, s_ready=1, in_capture=0, eng_valid=0, eng_o_ready=0, layer_sel=0, src_sel=0, buf_wr_en=0, buf_wr_sel=0, m_valid=0, busy=0, err_timeout=0, sample_cnt=0, last_latency=0.
- All outputs except in_capture are decoded from registered state. in_capture is combinational.
- Sample accepted at edge N gives LAUNCH in cycle N+1. With an idle engine the engine handshake completes at edge N+1.
- CAPTURE is exactly one cycle. The engine leaves DONE on that edge, so eng_ready is high in the following LAUNCH cycle.
- A back-to-back sample is not accepted in the m_ready cycle. s_ready rises the cycle after.
- Per-sample overhead beyond engine compute: 1 accept cycle, plus per layer (1 LAUNCH + 1 CAPTURE), plus ≥1 OUTPUT cycle.

## Test plan
- NUM_LAYERS=3, engine model with 10-cycle compute, m_ready=1, one sample.
  - Required: three launches with layer_sel 0,1,2 and src_sel 0,1,2.
  - Required: buf_wr_sel 0,1,0, then m_valid with out_sel=0.
  - Required: sample_cnt=1, last_latency=3×(10+2)+2.
- m_ready held low for 5 cycles in OUTPUT -> m_valid stays high, s_ready=0, sample_cnt increments only on m_ready.
- Engine eng_ready low for 4 cycles during LAUNCH -> eng_valid held, src_sel/layer_sel stable, no buf_wr_en.
- TIMEOUT_CYCLES=20, engine never asserts o_valid on layer 1.
  - Required: err_timeout=1 after 20 WAIT cycles, state ERROR, s_ready=0.
  - Required: clr_err returns to IDLE with err_timeout=0.
- abort asserted during WAIT of layer 1 -> next cycle IDLE, layer_sel=0, busy=0, sample_cnt unchanged; new sample completes normally.
- rst_n asserted mid-CAPTURE -> all outputs return to reset values immediately; no buf_wr_en after release.

Source files
------------

// File: rtl/snn_layer_scheduler.sv
// Per-sample sequencer for a shared dense-layer SNN engine: launches one engine
// pass per layer, steers the input mux and ping-pong buffers, presents the result.
module snn_layer_scheduler #(
  parameter int NUM_LAYERS     = 3,
  parameter int LAYER_W        = 4,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               in_capture,
  output logic               eng_valid,
  input  logic               eng_ready,
  input  logic               eng_o_valid,
  output logic               eng_o_ready,
  output logic [LAYER_W-1:0] layer_sel,
  output logic [1:0]         src_sel,
  output logic               buf_wr_en,
  output logic               buf_wr_sel,
  output logic               out_sel,
  output logic               m_valid,
  input  logic               m_ready,
  input  logic               abort,
  input  logic               clr_err,
  output logic               busy,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   last_latency
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CAPTURE,
    S_OUTPUT,
    S_ERROR
  } state_t;

  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam logic               OUT_BUF    = 1'((NUM_LAYERS - 1) % 2);

  state_t            state;
  logic [WD_W-1:0]   wdog;
  logic [CNT_W-1:0]  lat;
  logic [CNT_W-1:0]  lat_inc;

  assign lat_inc = (lat == '1) ? lat : lat + 1'b1;

  // Handshake and steering outputs are pure decodes of the state register.
  assign s_ready     = (state == S_IDLE);
  assign in_capture  = s_valid & s_ready;
  assign eng_valid   = (state == S_LAUNCH);
  assign eng_o_ready = (state == S_CAPTURE);
  assign buf_wr_en   = (state == S_CAPTURE);
  assign buf_wr_sel  = (state == S_CAPTURE) & layer_sel[0];
  assign m_valid     = (state == S_OUTPUT);
  assign busy        = (state != S_IDLE);
  assign out_sel     = OUT_BUF;

  // Layer k>0 reads the buffer written by layer k-1: odd layers read A, even read B.
  always_comb begin
    src_sel = 2'd0;
    if (layer_sel != '0) begin
      src_sel = layer_sel[0] ? 2'd1 : 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      layer_sel    <= '0;
      wdog         <= '0;
      lat          <= '0;
      err_timeout  <= 1'b0;
      sample_cnt   <= '0;
      last_latency <= '0;
    end else begin
      if (clr_err) begin
        err_timeout <= 1'b0;
      end
      if ((state != S_IDLE) && (state != S_ERROR)) begin
        lat <= lat_inc;
      end

      if (abort) begin
        state     <= S_IDLE;
        layer_sel <= '0;
        wdog      <= '0;
        lat       <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (s_valid) begin
              state     <= S_LAUNCH;
              layer_sel <= '0;
              // Accept cycle is counted here; the handshake cycle is added on capture.
              lat       <= CNT_W'(1);
            end
          end
          S_LAUNCH: begin
            if (eng_ready) begin
              state <= S_WAIT;
              wdog  <= '0;
            end
          end
          S_WAIT: begin
            if (eng_o_valid) begin
              state <= S_CAPTURE;
            end else if ((TIMEOUT_CYCLES != 0) && (wdog == WD_LAST)) begin
              state       <= S_ERROR;
              err_timeout <= 1'b1;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
          S_CAPTURE: begin
            if (layer_sel == LAST_LAYER) begin
              state <= S_OUTPUT;
            end else begin
              layer_sel <= layer_sel + 1'b1;
              state     <= S_LAUNCH;
            end
          end
          S_OUTPUT: begin
            if (m_ready) begin
              sample_cnt   <= sample_cnt + 1'b1;
              last_latency <= lat_inc;
              state        <= S_IDLE;
            end
          end
          S_ERROR: begin
            if (clr_err) begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snn_layer_scheduler.sv
// Bench for snn_layer_scheduler: behavioural engine model plus directed and
// randomized samples checked against latency/steering rules computed per sample.
module tb_snn_layer_scheduler;

  localparam int NL = 3;
  localparam int LW = 4;
  localparam int TO = 20;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          in_capture;
  logic          eng_valid;
  logic          eng_ready;
  logic          eng_o_valid;
  logic          eng_o_ready;
  logic [LW-1:0] layer_sel;
  logic [1:0]    src_sel;
  logic          buf_wr_en;
  logic          buf_wr_sel;
  logic          out_sel;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          abort = 1'b0;
  logic          clr_err = 1'b0;
  logic          busy;
  logic          err_timeout;
  logic [CW-1:0] sample_cnt;
  logic [CW-1:0] last_latency;

  always #5 clk = ~clk;

  snn_layer_scheduler #(
    .NUM_LAYERS(NL),
    .LAYER_W(LW),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .in_capture(in_capture),
    .eng_valid(eng_valid), .eng_ready(eng_ready),
    .eng_o_valid(eng_o_valid), .eng_o_ready(eng_o_ready),
    .layer_sel(layer_sel), .src_sel(src_sel),
    .buf_wr_en(buf_wr_en), .buf_wr_sel(buf_wr_sel), .out_sel(out_sel),
    .m_valid(m_valid), .m_ready(m_ready),
    .abort(abort), .clr_err(clr_err),
    .busy(busy), .err_timeout(err_timeout),
    .sample_cnt(sample_cnt), .last_latency(last_latency)
  );

  // Engine model: per-layer compute length, per-layer i_ready stall, optional hang.
  int comp [16];
  int stl [16];
  int hang_layer = -1;
  bit e_flush = 1'b0;
  bit e_busy = 1'b0;
  int e_left = 0;
  int e_layer = 0;
  int e_used [16];

  always @(posedge clk) begin
    if (e_flush) begin
      e_busy <= 1'b0;
      e_left <= 0;
      for (int i = 0; i < 16; i++) e_used[i] <= 0;
    end else if (!e_busy) begin
      if (eng_valid && eng_ready) begin
        e_busy  <= 1'b1;
        e_left  <= comp[layer_sel];
        e_layer <= int'(layer_sel);
      end else if (eng_valid) begin
        e_used[layer_sel] <= e_used[layer_sel] + 1;
      end
    end else if (eng_o_valid && eng_o_ready) begin
      e_busy <= 1'b0;
    end else if (e_left > 1) begin
      e_left <= e_left - 1;
    end
  end

  always_comb begin
    eng_ready   = !e_busy && (e_used[layer_sel] >= stl[layer_sel]);
    eng_o_valid = e_busy && (e_left == 1) && (e_layer != hang_layer);
  end

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  int exp_last = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic set_layers(input int c, input int s);
    for (int k = 0; k < 16; k++) begin
      comp[k] = c;
      stl[k]  = s;
    end
  endtask

  task automatic start_sample();
    e_flush = 1'b1;
    @(negedge clk);
    e_flush = 1'b0;
    check("idle_s_ready", 32'(s_ready), 1);
    s_valid = 1'b1;
    #1;
    check("in_capture", 32'(in_capture), 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_handshake(input int layer);
    int  guard;
    bit  found;
    guard = 0;
    found = 1'b0;
    while (!found && guard < 500) begin
      if (eng_valid && eng_ready && int'(layer_sel) == layer) found = 1'b1;
      else begin
        guard++;
        @(negedge clk);
      end
    end
    check("handshake_seen", 32'(found), 1);
  endtask

  task automatic run_sample(input int hold);
    int launches;
    int writes;
    int guard;
    int lat_exp;
    lat_exp = 1 + hold + 1;
    for (int k = 0; k < NL; k++) lat_exp += stl[k] + 1 + comp[k] + 1;
    start_sample();
    launches = 0;
    writes = 0;
    guard = 0;
    while (!m_valid && guard < 1000) begin
      if (eng_valid) begin
        check("launch_layer", 32'(layer_sel), launches);
        check("launch_src", 32'(src_sel), (launches == 0) ? 0 : 1 + (launches - 1) % 2);
        check("launch_no_wr", 32'(buf_wr_en), 0);
        if (eng_ready) launches++;
      end
      if (buf_wr_en) begin
        check("wr_sel", 32'(buf_wr_sel), writes % 2);
        check("wr_o_ready", 32'(eng_o_ready), 1);
        writes++;
      end
      guard++;
      @(negedge clk);
    end
    check("m_valid_seen", 32'(m_valid), 1);
    check("launch_count", launches, NL);
    check("write_count", writes, NL);
    check("out_sel", 32'(out_sel), (NL - 1) % 2);
    for (int i = 0; i < hold; i++) begin
      check("hold_m_valid", 32'(m_valid), 1);
      check("hold_s_ready", 32'(s_ready), 0);
      check("hold_cnt", 32'(sample_cnt), exp_cnt);
      @(negedge clk);
    end
    m_ready = 1'b1;
    check("out_m_valid", 32'(m_valid), 1);
    check("out_s_ready", 32'(s_ready), 0);
    @(negedge clk);
    m_ready = 1'b0;
    exp_cnt++;
    exp_last = lat_exp;
    check("sample_cnt", 32'(sample_cnt), exp_cnt);
    check("last_latency", 32'(last_latency), exp_last);
    check("back_idle", 32'(busy), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 1);
    check({tag, "_in_capture"}, 32'(in_capture), 0);
    check({tag, "_eng_valid"}, 32'(eng_valid), 0);
    check({tag, "_eng_o_ready"}, 32'(eng_o_ready), 0);
    check({tag, "_layer_sel"}, 32'(layer_sel), 0);
    check({tag, "_src_sel"}, 32'(src_sel), 0);
    check({tag, "_buf_wr_en"}, 32'(buf_wr_en), 0);
    check({tag, "_buf_wr_sel"}, 32'(buf_wr_sel), 0);
    check({tag, "_m_valid"}, 32'(m_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(err_timeout), 0);
    check({tag, "_cnt"}, 32'(sample_cnt), 0);
    check({tag, "_lat"}, 32'(last_latency), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int wcnt;
    int guard;
    set_layers(10, 0);
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Baseline: 10-cycle engine, immediate m_ready.
    run_sample(0);
    check("latency_38", 32'(last_latency), 3 * (10 + 2) + 2);

    // Downstream back-pressure for 5 cycles.
    run_sample(5);
    check("latency_43", 32'(last_latency), 43);

    // Engine holds i_ready low for 4 cycles at layer 1's launch.
    stl[1] = 4;
    run_sample(0);
    check("latency_42", 32'(last_latency), 42);
    set_layers(10, 0);

    // Watchdog: layer 1 never produces a result.
    set_layers(5, 0);
    hang_layer = 1;
    start_sample();
    wait_handshake(1);
    @(negedge clk);
    wcnt = 0;
    while (!err_timeout && wcnt < 100) begin
      wcnt++;
      @(negedge clk);
    end
    check("wait_cycles", wcnt, TO);
    check("to_err", 32'(err_timeout), 1);
    check("to_s_ready", 32'(s_ready), 0);
    check("to_busy", 32'(busy), 1);
    check("to_eng_valid", 32'(eng_valid), 0);
    check("to_m_valid", 32'(m_valid), 0);
    @(negedge clk);
    check("to_err_sticky", 32'(err_timeout), 1);
    check("to_still_busy", 32'(busy), 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("clr_err", 32'(err_timeout), 0);
    check("clr_idle", 32'(s_ready), 1);
    check("clr_busy", 32'(busy), 0);
    check("to_cnt", 32'(sample_cnt), exp_cnt);
    hang_layer = -1;

    // Abort in WAIT of layer 1, then a normal sample.
    set_layers(8, 0);
    start_sample();
    wait_handshake(1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", 32'(busy), 0);
    check("ab_layer", 32'(layer_sel), 0);
    check("ab_s_ready", 32'(s_ready), 1);
    check("ab_cnt", 32'(sample_cnt), exp_cnt);
    check("ab_lat", 32'(last_latency), exp_last);
    run_sample(1);

    // Randomized samples.
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < NL; k++) begin
        comp[k] = int'($urandom_range(1, 12));
        stl[k]  = int'($urandom_range(0, 3));
      end
      run_sample(int'($urandom_range(0, 4)));
    end

    // Asynchronous reset during CAPTURE.
    set_layers(4, 0);
    start_sample();
    guard = 0;
    while (!buf_wr_en && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    check("rst_in_capture", 32'(buf_wr_en), 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    exp_last = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_wr", 32'(buf_wr_en), 0);
      check("post_rst_idle", 32'(busy), 0);
    end
    set_layers(3, 0);
    run_sample(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
